// File: rtl/serial_add_nbit_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings, width limit and
// the bit-counter sizing helper.
package serial_add_nbit_pkg;

    localparam int unsigned WIDTH_MAX = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter holds 0..WIDTH-1 plus one spare bit so it never wraps inside ADD.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_add_nbit_if.sv
// Request/result bundle of the bit-serial adder; master issues operands,
// slave (the adder) returns the handshake and the held result.
interface serial_add_nbit_if #(
    parameter int unsigned WIDTH = 2
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_nbit_full_add_1bit.sv
// Single full-adder cell built from gate primitives, mirroring the
// subtractor's borrow cell.
module full_add_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;
    logic g;
    logic t;

    xor g_xor_p (p, a, b);
    xor g_xor_s (s, p, cin);
    and g_and_g (g, a, b);
    and g_and_t (t, p, cin);
    or  g_or_c  (cout, g, t);
endmodule

// File: rtl/serial_add_nbit.sv
// Bit-serial WIDTH-bit adder: one full-adder cell walks the operands LSB-first,
// producing {cout,sum} = a + b + cin under a start/busy/done handshake.
module serial_add_nbit
    import serial_add_nbit_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_nbit_if.slave bus
);
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_add_nbit: WIDTH must be within 1..32");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] bit_mask_c;
    logic             a_bit_c;
    logic             b_bit_c;
    logic             fa_s_c;
    logic             fa_co_c;

    // Operand bit selected by the counter via a one-hot mask.
    assign bit_mask_c = WIDTH'(1) << cnt_q;
    assign a_bit_c    = |(a_q & bit_mask_c);
    assign b_bit_c    = |(b_q & bit_mask_c);

    full_add_1bit u_fa (
        .a    (a_bit_c),
        .b    (b_bit_c),
        .cin  (c_q),
        .s    (fa_s_c),
        .cout (fa_co_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = bus.cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                sum_d = sum_q | (WIDTH'(fa_s_c) << cnt_q);
                c_d   = fa_co_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cout_d  = fa_co_c;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
